// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Arbiter FSM state and the word-size code used for debug beats.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module arb_sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != LIM)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the MEM stage and a debug port.
// Core has priority; debug gets starvation relief and bounded bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic                  core_stall,
  output logic [DATA_W-1:0]     core_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic                  dbg_lock,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] S_LIM = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] B_MAX = BW'(BURST_MAX);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic          rsp_dbg_q;
  logic          rsp_dbg_d;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic          core_act;
  logic          dbg_sel;
  logic          burst_ok;
  logic          beat_adv;

  assign core_act = core_rd | core_wr;
  assign burst_ok = (state_q == BURST) && (beat_cnt < B_MAX);

  // Outputs must read 0 while reset is held, so the grant is gated too.
  assign dbg_sel = reset_n & dbg_req &
                   (!core_act | (starve_cnt == S_LIM) | burst_ok);

  assign dbg_gnt    = dbg_sel;
  assign core_stall = core_act & dbg_sel;
  assign beat_adv   = dbg_sel & dbg_lock;

  always_comb begin
    state_d   = beat_adv ? BURST : IDLE;
    rsp_dbg_d = dbg_sel & !dbg_we;
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = '0;
    if (dbg_sel) begin
      mem_rd    = !dbg_we;
      mem_wr    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_func3 = FUNC3_WORD;
    end else if (reset_n) begin
      mem_rd    = core_rd & !core_wr;
      mem_wr    = core_wr;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_func3 = core_func3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rsp_dbg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_dbg_q <= rsp_dbg_d;
    end
  end

  arb_sat_counter #(
    .W     (SW),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (dbg_sel),
    .inc     (dbg_req & !dbg_sel),
    .cnt     (starve_cnt)
  );

  // Any beat that does not continue a locked burst ends it.
  arb_sat_counter #(
    .W     (BW),
    .LIMIT (BURST_MAX)
  ) u_beat (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!beat_adv),
    .inc     (beat_adv),
    .cnt     (beat_cnt)
  );

  assign dbg_rvalid = rsp_dbg_q;
  assign dbg_rdata  = rsp_dbg_q ? mem_rdata : '0;
  assign core_rdata = reset_n ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset_n)
      a_core_rdwr: assert (!(core_rd && core_wr))
        else $warning("dmem_arbiter: core_rd and core_wr both high, write taken");
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_rd, core_wr;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_func3;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [512];

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  dmem_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_rd    (core_rd),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_func3 (core_func3),
    .core_stall (core_stall),
    .core_rdata (core_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_func3  (mem_func3),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    core_rd = 0; core_wr = 0; core_addr = '0;
    core_wdata = '0; core_func3 = 3'b000;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    dbg_addr = '0; dbg_wdata = '0;
  endtask

  initial begin
    idle();
    reset_n = 0;
    core_wr = 1; core_addr = 9'h1FF; core_wdata = 32'hFFFF_FFFF;
    dbg_req = 1;
    @(negedge clk); #1;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_rvalid", dbg_rvalid, 0);

    @(negedge clk); idle(); reset_n = 1;

    // core write then read back
    @(negedge clk);
    core_wr = 1; core_addr = 9'h010; core_wdata = 32'hDEADBEEF;
    core_func3 = 3'b010; #1;
    chk("c_wr_stall", core_stall, 0);
    chk("c_wr_mem_wr", mem_wr, 1);
    chk("c_wr_addr", mem_addr, 9'h010);
    @(negedge clk);
    core_wr = 0; core_rd = 1; #1;
    chk("c_rd_stall", core_stall, 0);
    chk("c_rd_mem_rd", mem_rd, 1);
    @(negedge clk); idle(); #1;
    chk("c_rdata", core_rdata, 32'hDEADBEEF);

    // debug write then read with core idle
    @(negedge clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020;
    dbg_wdata = 32'hCAFEF00D; core_func3 = 3'b001; #1;
    chk("d_wr_gnt", dbg_gnt, 1);
    chk("d_wr_mem_wr", mem_wr, 1);
    chk("d_wr_func3", mem_func3, 3'b010);
    @(negedge clk);
    dbg_we = 0; #1;
    chk("d_rd_gnt", dbg_gnt, 1);
    chk("d_rd_mem_rd", mem_rd, 1);
    chk("d_rd_stall", core_stall, 0);
    chk("d_wr_no_rvalid", dbg_rvalid, 0);
    @(negedge clk); idle(); #1;
    chk("d_rvalid", dbg_rvalid, 1);
    chk("d_rdata", dbg_rdata, 32'hCAFEF00D);
    @(negedge clk); #1;
    chk("d_rvalid_off", dbg_rvalid, 0);
    chk("d_rdata_zero", dbg_rdata, 0);

    // starvation: 8 denied cycles, then a forced grant
    @(negedge clk);
    core_rd = 1; core_addr = 9'h010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("st_deny%0d", i), dbg_gnt, 0);
      if (i == 0) chk("st_core_addr", mem_addr, 9'h010);
      @(negedge clk);
    end
    #1;
    chk("st_gnt", dbg_gnt, 1);
    chk("st_stall", core_stall, 1);
    chk("st_addr", mem_addr, 9'h020);
    @(negedge clk); #1;
    chk("st_cleared", dbg_gnt, 0);
    chk("st_stall_off", core_stall, 0);
    chk("st_rvalid", dbg_rdata, 32'hCAFEF00D);
    @(negedge clk); idle();

    // burst bound with core arriving at beat 2
    @(negedge clk);
    dbg_req = 1; dbg_we = 1; dbg_lock = 1;
    dbg_addr = 9'h000; dbg_wdata = 32'h11111111; #1;
    chk("b1_gnt", dbg_gnt, 1);
    @(negedge clk);
    dbg_addr = 9'h004; dbg_wdata = 32'h22222222;
    core_rd = 1; core_addr = 9'h008; #1;
    chk("b2_gnt", dbg_gnt, 1);
    chk("b2_stall", core_stall, 1);
    @(negedge clk);
    dbg_addr = 9'h008; dbg_wdata = 32'h33333333; #1;
    chk("b3_gnt", dbg_gnt, 1);
    chk("b3_stall", core_stall, 1);
    @(negedge clk);
    dbg_addr = 9'h00C; dbg_wdata = 32'h44444444; #1;
    chk("b4_gnt", dbg_gnt, 1);
    chk("b4_stall", core_stall, 1);
    @(negedge clk);
    dbg_addr = 9'h010; dbg_wdata = 32'h55555555; #1;
    chk("b5_gnt", dbg_gnt, 0);
    chk("b5_stall", core_stall, 0);
    chk("b5_mem_rd", mem_rd, 1);
    chk("b5_addr", mem_addr, 9'h008);
    @(negedge clk);
    core_addr = 9'h00C; #1;
    chk("b6_idle_deny", dbg_gnt, 0);
    chk("b6_rdata", core_rdata, 32'h33333333);
    @(negedge clk);
    core_rd = 0; dbg_lock = 0; #1;
    chk("b7_gnt", dbg_gnt, 1);
    chk("b7_rdata", core_rdata, 32'h44444444);
    @(negedge clk); idle();

    // async reset with a debug read in flight
    @(negedge clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020; #1;
    chk("r_gnt", dbg_gnt, 1);
    @(posedge clk); #1;
    chk("r_rvalid_pre", dbg_rvalid, 1);
    reset_n = 0; #1;
    chk("r_rvalid", dbg_rvalid, 0);
    chk("r_gnt_off", dbg_gnt, 0);
    chk("r_mem_rd", mem_rd, 0);
    chk("r_dbg_rdata", dbg_rdata, 0);
    chk("r_core_rdata", core_rdata, 0);
    @(negedge clk); idle();
    @(negedge clk); reset_n = 1; #1;
    chk("r_rel_rvalid", dbg_rvalid, 0);
    @(negedge clk);
    core_rd = 1; core_addr = 9'h020; #1;
    chk("r_rel_rvalid2", dbg_rvalid, 0);
    chk("r_core_stall", core_stall, 0);
    chk("r_core_mem_rd", mem_rd, 1);
    @(negedge clk); idle(); #1;
    chk("r_core_rdata2", core_rdata, 32'hCAFEF00D);

    // illegal read+write: write wins
    @(negedge clk);
    core_rd = 1; core_wr = 1; core_addr = 9'h030;
    core_wdata = 32'h12345678; #1;
    chk("il_mem_wr", mem_wr, 1);
    chk("il_mem_rd", mem_rd, 0);
    @(negedge clk);
    core_wr = 0; #1;
    chk("il_rd", mem_rd, 1);
    @(negedge clk); idle(); #1;
    chk("il_rdata", core_rdata, 32'h12345678);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (core port) and a debug/loader port (dbg port).
- Sits between the EX/MEM pipeline register outputs and the datamemory instance.
- Issues at most one access per cycle; the core has priority, with starvation protection and bounded debug bursts.
- Drives a stall to the pipeline's hazard logic whenever a core access is deferred.

Parameters:
- DM_ADDRESS, 9, data memory address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, consecutive denied dbg cycles before dbg is forced a grant.
- BURST_MAX, 4, maximum consecutive dbg beats under dbg_lock while the core is requesting.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_rd  in  1  MEM-stage read enable.
- core_wr  in  1  MEM-stage write enable.
- core_addr  in  DM_ADDRESS  MEM-stage address.
- core_wdata  in  DATA_W  MEM-stage store data.
- core_func3  in  3  load/store size code, passed to memory.
- core_stall  out  1  core access not performed this cycle; pipeline must hold.
- core_rdata  out  DATA_W  mem_rdata, valid the cycle after a granted core read.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_lock  in  1  keep ownership for following beats (burst).
- dbg_addr  in  DM_ADDRESS  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug beat accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- mem_rd, mem_wr  out  1 each  memory enables.
- mem_addr  out  DM_ADDRESS  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_func3  out  3  memory size code.
- mem_rdata  in  DATA_W  memory read data, synchronous, one cycle after mem_rd.

Behaviour:
- Reset value of every output is 0:
  - While reset_n = 0: mem_rd, mem_wr, core_stall, dbg_gnt, dbg_rvalid are 0; all address/data outputs are 0.
  - starve_cnt, beat_cnt, state and rsp registers clear asynchronously.
  - A reset mid-burst or with a read in flight drops it; there is no rvalid after reset release.
- Definitions:
  - core_act = core_rd | core_wr.
  - core_rd and core_wr both high is illegal; write wins and an assertion fires.
- FSM states: IDLE, BURST.
- Owner selection is combinational, same cycle:
  - dbg_sel = dbg_req & (!core_act | starve_cnt == STARVE_LIMIT | (state == BURST & beat_cnt < BURST_MAX)).
  - dbg_gnt = dbg_sel.
  - core_stall = core_act & dbg_sel.
- Memory muxing:
  - dbg_sel = 1: mem_* come from the dbg port, with mem_func3 = 3'b010 (word).
  - Otherwise: mem_* come from the core port; mem_rd/mem_wr are 0 when core_act = 0.
- starve_cnt:
  - Cleared on dbg_gnt.
  - Increments, saturating at STARVE_LIMIT, when dbg_req & !dbg_gnt.
  - Held otherwise.
- FSM transitions:
  - IDLE -> BURST on dbg_gnt & dbg_lock; beat_cnt := 1.
  - BURST, dbg_gnt & dbg_lock: stay; beat_cnt increments, saturating at BURST_MAX.
  - BURST, !dbg_req or !dbg_lock: -> IDLE; beat_cnt := 0.
  - BURST, beat_cnt == BURST_MAX & core_act: dbg denied for that cycle; -> IDLE, beat_cnt := 0.
  - The core always wins at least one cycle per BURST_MAX dbg beats.
  - With core_act = 0, bursts are unbounded; beat_cnt saturates and has no effect.
- Read response:
  - rsp_dbg register := dbg_gnt & !dbg_we.
  - dbg_rvalid = rsp_dbg; dbg_rdata = mem_rdata when rsp_dbg = 1, else 0.
  - core_rdata = mem_rdata unconditionally; the pipeline samples it.
- Latency:
  - Writes take effect at the grant edge.
  - Read data arrives 1 cycle after the grant.
  - Core stall adds exactly 1 cycle per denied cycle.
- Simultaneous events:
  - Starvation-forced grant and a fresh burst may coincide; a forced grant with dbg_lock enters BURST normally.
  - The core is never starved for more than BURST_MAX consecutive cycles.

Decomposition:
- Shared package (alongside Pipe_Buf_Reg_PKG):
  - arb_state_t enum {IDLE, BURST}.
  - FUNC3_WORD = 3'b010.
- One natural sub-module, arb_sat_counter (width/limit parameterized, clear/inc/saturate), instantiated twice: starve_cnt and beat_cnt.

Test Plan:
- Core-only traffic: core_wr = 1, addr = 9'h010, wdata = 32'hDEADBEEF; next cycle core_rd addr = 9'h010 -> core_stall = 0 throughout; mem_wr, then mem_rd asserted; core_rdata = 32'hDEADBEEF one cycle after the read.
- Debug while core idle: dbg_req = 1, dbg_we = 0, addr = 9'h020 -> dbg_gnt the same cycle; dbg_rvalid = 1 next cycle with the stored word; core_stall = 0.
- Starvation, STARVE_LIMIT = 8: core_rd held continuously, dbg_req held -> dbg denied 8 cycles; 9th cycle dbg_gnt = 1 and core_stall = 1; starve_cnt returns to 0.
- Burst bound, BURST_MAX = 4: core idle then dbg_lock writes to 9'h000..9'h00C, core_rd raised at beat 2 -> dbg granted for beats 2..4; 5th cycle dbg_gnt = 0 and the core access proceeds with core_stall = 0; state = IDLE.
- Async reset mid-read: dbg read granted, reset_n pulled low before the next edge -> all outputs 0 immediately; no dbg_rvalid after release; the first core access after release is not stalled.
- Illegal core_rd & core_wr = 1 -> mem_wr = 1, mem_rd = 0, assertion reported.
